// File: rtl/dcu_pkg.sv
// rtl/dcu_pkg.sv - states, opcodes, ALU codes and IR field positions shared by the control unit
package dcu_pkg;

    typedef enum logic [3:0] {
        IDLE, T0, T1, T2, T3, T4, T5, T6, T7, HALT
    } dcuState_t;

    localparam logic [4:0] ALU_ADD = 5'd3;
    localparam logic [4:0] ALU_SUB = 5'd4;
    localparam logic [4:0] ALU_AND = 5'd5;
    localparam logic [4:0] ALU_OR  = 5'd6;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01000;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam int OP_HI = 31;
    localparam int OP_LO = 27;
    localparam int RA_HI = 26;
    localparam int RA_LO = 23;
    localparam int RB_HI = 22;
    localparam int RB_LO = 19;
    localparam int RC_HI = 18;
    localparam int RC_LO = 15;
    localparam int C_HI  = 18;
    localparam int C_LO  = 0;

    typedef struct packed {
        logic       pcOut;
        logic       zloOut;
        logic       mdrOut;
        logic       cOut;
        logic       rOut;
        logic       baOut;
        logic       pcIn;
        logic       irIn;
        logic       marIn;
        logic       mdrIn;
        logic       yIn;
        logic       zIn;
        logic       rIn;
        logic       gra;
        logic       grb;
        logic       grc;
        logic       incPc;
        logic       read;
        logic       write;
        logic       illegal;
        logic [4:0] aluControl;
    } ctrl_t;

    function automatic logic opIsAlu(input logic [4:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

    // ld, ldi and st all form C + (Rb or 0) in T3..T4
    function automatic logic opUsesOffset(input logic [4:0] op);
        return (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);
    endfunction

    function automatic logic opIsDefined(input logic [4:0] op);
        return opUsesOffset(op) || opIsAlu(op) || (op == OP_ADDI);
    endfunction

    function automatic logic [4:0] aluFor(input logic [4:0] op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/dcu_decode.sv
// rtl/dcu_decode.sv - combinational map of sequencer state and opcode to the control-strobe bundle
module dcu_decode
    import dcu_pkg::*;
(
    input  dcuState_t  state,
    input  logic [4:0] op,
    input  logic       memRdy,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            T0: begin
                ctrl.pcOut      = 1'b1;
                ctrl.marIn      = 1'b1;
                ctrl.incPc      = 1'b1;
                ctrl.zIn        = 1'b1;
                ctrl.aluControl = ALU_ADD;
            end
            T1: begin
                // PC only reloads once the fetch read completes, so a stall cannot double-increment
                ctrl.zloOut = 1'b1;
                ctrl.read   = 1'b1;
                ctrl.mdrIn  = 1'b1;
                ctrl.pcIn   = memRdy;
            end
            T2: begin
                ctrl.mdrOut = 1'b1;
                ctrl.irIn   = 1'b1;
            end
            T3: begin
                if (opUsesOffset(op)) begin
                    ctrl.grb   = 1'b1;
                    ctrl.baOut = 1'b1;
                    ctrl.yIn   = 1'b1;
                end else if (opIsAlu(op) || (op == OP_ADDI)) begin
                    ctrl.grb  = 1'b1;
                    ctrl.rOut = 1'b1;
                    ctrl.yIn  = 1'b1;
                end else if (op != OP_HALT) begin
                    ctrl.illegal = 1'b1;
                end
            end
            T4: begin
                ctrl.zIn = 1'b1;
                if (opIsAlu(op)) begin
                    ctrl.grc        = 1'b1;
                    ctrl.rOut       = 1'b1;
                    ctrl.aluControl = aluFor(op);
                end else begin
                    ctrl.cOut       = 1'b1;
                    ctrl.aluControl = ALU_ADD;
                end
            end
            T5: begin
                ctrl.zloOut = 1'b1;
                if ((op == OP_LD) || (op == OP_ST)) begin
                    ctrl.marIn = 1'b1;
                end else begin
                    ctrl.gra = 1'b1;
                    ctrl.rIn = 1'b1;
                end
            end
            T6: begin
                ctrl.mdrIn = 1'b1;
                if (op == OP_LD) begin
                    ctrl.read = 1'b1;
                end else begin
                    ctrl.gra  = 1'b1;
                    ctrl.rOut = 1'b1;
                end
            end
            T7: begin
                if (op == OP_LD) begin
                    ctrl.mdrOut = 1'b1;
                    ctrl.gra    = 1'b1;
                    ctrl.rIn    = 1'b1;
                end else begin
                    ctrl.write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/datapath_control_unit.sv
// rtl/datapath_control_unit.sv - hardwired fetch/execute sequencer for the single-bus datapath
// Optional DCU_SINGLE_STEP_EN: one instruction per rising edge of run.
module datapath_control_unit
    import dcu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             run,
    input  logic [31:0]      ir,
    input  logic             mem_rdy,
    output logic             PCout,
    output logic             ZLOout,
    output logic             MDRout,
    output logic             Cout,
    output logic             Rout,
    output logic             BAout,
    output logic             PCin,
    output logic             IRin,
    output logic             MARin,
    output logic             MDRin,
    output logic             Yin,
    output logic             Zin,
    output logic             Rin,
    output logic             Gra,
    output logic             Grb,
    output logic             Grc,
    output logic             IncPC,
    output logic             Read,
    output logic             Write,
    output logic [4:0]       aluControl,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    dcuState_t  state;
    dcuState_t  stateNext;
    ctrl_t      ctrl;
    logic [4:0] op;
    logic       endInstr;
    logic       startReq;
    logic       keepRunning;
    logic       unusedIrBits;

    assign op = ir[OP_HI:OP_LO];
    assign unusedIrBits = ^{ir[RA_HI:RA_LO], ir[RB_HI:RB_LO], ir[RC_HI:RC_LO], ir[C_HI:C_LO]};

`ifdef DCU_SINGLE_STEP_EN
    logic runPrev;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            runPrev <= 1'b0;
        end else begin
            runPrev <= run;
        end
    end

    assign startReq    = run & ~runPrev;
    assign keepRunning = 1'b0;
`else
    assign startReq    = run;
    assign keepRunning = run;
`endif

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        endInstr  = 1'b0;
        case (state)
            IDLE: if (startReq) stateNext = T0;
            T0:   stateNext = T1;
            T1:   if (mem_rdy) stateNext = T2;
            T2:   stateNext = T3;
            T3: begin
                if (op == OP_HALT) begin
                    stateNext = HALT;
                end else if (opIsDefined(op)) begin
                    stateNext = T4;
                end else begin
                    endInstr = 1'b1;
                end
            end
            T4:   stateNext = T5;
            T5: begin
                if ((op == OP_LD) || (op == OP_ST)) begin
                    stateNext = T6;
                end else begin
                    endInstr = 1'b1;
                end
            end
            // ld waits for its data read in T6; st waits for its write in T7
            T6:   if ((op == OP_ST) || mem_rdy) stateNext = T7;
            T7:   if ((op == OP_LD) || mem_rdy) endInstr = 1'b1;
            HALT: stateNext = HALT;
            default: stateNext = IDLE;
        endcase
        if (endInstr) begin
            stateNext = keepRunning ? T0 : IDLE;
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            instr_count <= '0;
        end else if (endInstr && opIsDefined(op)) begin
            instr_count <= instr_count + CNT_W'(1);
        end
    end

    dcu_decode u_decode (
        .state  (state),
        .op     (op),
        .memRdy (mem_rdy),
        .ctrl   (ctrl)
    );

    assign PCout      = ctrl.pcOut;
    assign ZLOout     = ctrl.zloOut;
    assign MDRout     = ctrl.mdrOut;
    assign Cout       = ctrl.cOut;
    assign Rout       = ctrl.rOut;
    assign BAout      = ctrl.baOut;
    assign PCin       = ctrl.pcIn;
    assign IRin       = ctrl.irIn;
    assign MARin      = ctrl.marIn;
    assign MDRin      = ctrl.mdrIn;
    assign Yin        = ctrl.yIn;
    assign Zin        = ctrl.zIn;
    assign Rin        = ctrl.rIn;
    assign Gra        = ctrl.gra;
    assign Grb        = ctrl.grb;
    assign Grc        = ctrl.grc;
    assign IncPC      = ctrl.incPc;
    assign Read       = ctrl.read;
    assign Write      = ctrl.write;
    assign aluControl = ctrl.aluControl;
    assign illegal    = ctrl.illegal;
    assign halted     = (state == HALT);

endmodule

// File: tb/tb_datapath_control_unit.sv
// tb/tb_datapath_control_unit.sv - randomized self-checking bench for datapath_control_unit
module tb_datapath_control_unit;

    logic        clock = 1'b0;
    logic        clear;
    logic        run;
    logic [31:0] ir;
    logic        mem_rdy;
    logic PCout, ZLOout, MDRout, Cout, Rout, BAout;
    logic PCin, IRin, MARin, MDRin, Yin, Zin, Rin;
    logic Gra, Grb, Grc, IncPC, Read, Write;
    logic [4:0]  aluControl;
    logic        halted;
    logic        illegal;
    logic [15:0] instr_count;

    int tests  = 0;
    int failed = 0;
    int expCnt = 0;

    typedef struct packed {
        logic pcOut, zloOut, mdrOut, cOut, rOut, baOut;
        logic pcIn, irIn, marIn, mdrIn, yIn, zIn, rIn;
        logic gra, grb, grc, incPc, read, write, illegal;
        logic [4:0] alu;
    } obs_t;

    obs_t trace [0:63];

    datapath_control_unit #(.CNT_W(16)) dut (
        .clock(clock), .clear(clear), .run(run), .ir(ir), .mem_rdy(mem_rdy),
        .PCout(PCout), .ZLOout(ZLOout), .MDRout(MDRout), .Cout(Cout), .Rout(Rout), .BAout(BAout),
        .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .Zin(Zin), .Rin(Rin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .IncPC(IncPC), .Read(Read), .Write(Write),
        .aluControl(aluControl), .halted(halted), .illegal(illegal), .instr_count(instr_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic obs_t sampleNow();
        obs_t o;
        o = {PCout, ZLOout, MDRout, Cout, Rout, BAout, PCin, IRin, MARin, MDRin, Yin, Zin, Rin,
             Gra, Grb, Grc, IncPC, Read, Write, illegal, aluControl};
        return o;
    endfunction

    function automatic logic [31:0] obsBits(input obs_t o);
        return {7'd0, o};
    endfunction

    // Runs one instruction starting in its T0 cycle (entered 2 time units after posedge).
    // Reference: fetch takes 3+w1 cycles; ALU/ldi/addi add 3, ld/st add 5+w2, illegal adds 1.
    task automatic runInstr(input logic [31:0] irVal, input int w1, input int w2);
        logic [4:0] op;
        bit isLd, isSt, isLdi, isAddi, isAlu, legal;
        int len, reads, writes, pcins, irins, rins, gras, ills, zExec, busBad;
        logic [4:0] aluSeen, aluExp;
        op     = irVal[31:27];
        isLd   = (op == 5'd0);
        isLdi  = (op == 5'd1);
        isSt   = (op == 5'd2);
        isAlu  = (op >= 5'd3) && (op <= 5'd6);
        isAddi = (op == 5'd8);
        legal  = isLd || isLdi || isSt || isAlu || isAddi;
        if (isLd || isSt) len = 8 + w1 + w2;
        else if (legal)   len = 6 + w1;
        else              len = 4 + w1;
        for (int c = 0; c < len; c++) begin
            if (c == 0) ir = irVal;
            mem_rdy = 1'($urandom_range(0, 1));
            if (c >= 1 && c <= 1 + w1) mem_rdy = (c == 1 + w1);
            if (isLd && c >= w1 + 6 && c <= w1 + 6 + w2) mem_rdy = (c == w1 + 6 + w2);
            if (isSt && c >= w1 + 7 && c <= w1 + 7 + w2) mem_rdy = (c == w1 + 7 + w2);
            #1;
            trace[c] = sampleNow();
            if (c == 0) begin
                check("count_at_start", 32'(instr_count), 32'(expCnt));
                check("t0_fetch", 32'(PCout & MARin & IncPC & Zin), 32'd1);
            end
            @(posedge clock);
            #2;
        end
        reads = 0; writes = 0; pcins = 0; irins = 0; rins = 0; gras = 0; ills = 0; zExec = 0; busBad = 0;
        aluSeen = 5'h1f;
        for (int c = 0; c < len; c++) begin
            reads  += int'(trace[c].read);
            writes += int'(trace[c].write);
            pcins  += int'(trace[c].pcIn);
            irins  += int'(trace[c].irIn);
            rins   += int'(trace[c].rIn);
            gras   += int'(trace[c].gra);
            ills   += int'(trace[c].illegal);
            if ($countones({trace[c].pcOut, trace[c].zloOut, trace[c].mdrOut,
                            trace[c].cOut, trace[c].rOut, trace[c].baOut}) > 1) busBad++;
            if (trace[c].zIn && !trace[c].pcOut) begin
                zExec++;
                aluSeen = trace[c].alu;
            end
        end
        case (op)
            5'd4:    aluExp = 5'd4;
            5'd5:    aluExp = 5'd5;
            5'd6:    aluExp = 5'd6;
            default: aluExp = legal ? 5'd3 : 5'h1f;
        endcase
        check("read_cycles",  32'(reads),  32'((w1 + 1) + (isLd ? w2 + 1 : 0)));
        check("write_cycles", 32'(writes), 32'(isSt ? w2 + 1 : 0));
        check("pcin_pulses",  32'(pcins),  32'd1);
        check("irin_pulses",  32'(irins),  32'd1);
        check("rin_cycles",   32'(rins),   32'((legal && !isSt) ? 1 : 0));
        check("gra_cycles",   32'(gras),   32'(legal ? 1 : 0));
        check("illegal_cyc",  32'(ills),   32'(legal ? 0 : 1));
        check("alu_exec_cyc", 32'(zExec),  32'(legal ? 1 : 0));
        check("alu_code",     32'(aluSeen), 32'(aluExp));
        check("bus_onehot",   32'(busBad), 32'd0);
        if (legal) expCnt = (expCnt + 1) & 16'hffff;
    endtask

    initial begin
        logic [31:0] irVal;
        logic [4:0]  op;
        int          w1;
        clear = 1'b1; run = 1'b0; ir = 32'd0; mem_rdy = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        clear = 1'b0;
        #1;
        check("reset_strobes", obsBits(sampleNow()), 32'd0);
        check("reset_halted", 32'(halted), 32'd0);
        check("reset_count", 32'(instr_count), 32'd0);

        run = 1'b1;
        @(posedge clock);
        #2;
        runInstr(32'h18918000, 0, 0);
        check("add_t4_grc_rout_zin", 32'(trace[4].grc & trace[4].rOut & trace[4].zIn), 32'd1);
        check("add_t4_alu", 32'(trace[4].alu), 32'd3);
        check("add_t5_gra_rin", 32'(trace[5].gra & trace[5].rIn & trace[5].zloOut), 32'd1);

        runInstr({5'b00000, 4'd1, 4'd2, 19'h4}, 3, 2);

        runInstr({5'b00010, 4'd5, 4'd0, 19'h10}, 1, 2);
        check("st_t3_baout", 32'({trace[4].baOut, trace[4].rOut}), 32'b10);
        check("st_t6_gra_rout_mdrin", 32'(trace[7].gra & trace[7].rOut & trace[7].mdrIn & !trace[7].read), 32'd1);

        runInstr({5'b10101, 27'h0}, 0, 0);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 8))
                0: op = 5'd0;
                1: op = 5'd1;
                2: op = 5'd2;
                3: op = 5'd3;
                4: op = 5'd4;
                5: op = 5'd5;
                6: op = 5'd6;
                7: op = 5'd8;
                default: begin
                    op = 5'd0;
                    for (int k = 0; k < 64 && (op <= 5'd6 || op == 5'd8 || op == 5'd27); k++)
                        op = 5'($urandom_range(9, 31));
                    if (op == 5'd27) op = 5'd21;
                end
            endcase
            irVal = {op, 27'($urandom)};
            w1 = int'($urandom_range(0, 3));
            runInstr(irVal, w1, int'($urandom_range(0, 3)));
        end

        run = 1'b0;
        runInstr({5'b00011, 27'h0}, 0, 0);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("idle_after_run_low", obsBits(sampleNow()), 32'd0);
            check("idle_count", 32'(instr_count), 32'(expCnt));
            @(posedge clock);
            #2;
        end

        run = 1'b1;
        @(posedge clock);
        #2;
        ir = {5'b11011, 27'h0};
        mem_rdy = 1'b1;
        repeat (4) begin
            @(posedge clock);
            #2;
        end
        for (int k = 0; k < 20; k++) begin
            #1;
            check("halt_halted", 32'(halted), 32'd1);
            check("halt_strobes", obsBits(sampleNow()), 32'd0);
            @(posedge clock);
            #2;
        end
        check("halt_count_kept", 32'(instr_count), 32'(expCnt));
        clear = 1'b1;
        #1;
        check("halt_clear_halted", 32'(halted), 32'd0);
        check("halt_clear_count", 32'(instr_count), 32'd0);
        @(negedge clock);
        clear = 1'b0;
        expCnt = 0;

        @(posedge clock);
        #2;
        runInstr({5'b00011, 27'h0}, 0, 0);
        ir = {5'b00000, 4'd3, 4'd4, 19'h8};
        mem_rdy = 1'b1;
        repeat (6) begin
            @(posedge clock);
            #2;
        end
        mem_rdy = 1'b0;
        #1;
        check("ld_t6_read", 32'(Read & MDRin), 32'd1);
        check("ld_t6_count", 32'(instr_count), 32'd1);
        clear = 1'b1;
        #1;
        check("clear_mid_strobes", obsBits(sampleNow()), 32'd0);
        check("clear_mid_count", 32'(instr_count), 32'd0);
        run = 1'b0;
        @(negedge clock);
        clear = 1'b0;
        @(posedge clock);
        #3;
        check("clear_mid_idle", obsBits(sampleNow()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/datapath_control_unit.md
Name: datapath_control_unit

Overview:
- Hardwired Moore sequencer that drives the single-bus datapath's control inputs: bus-source enables, register-load enables, register-select strobes, ALU op and memory strobes.
- Each instruction runs as a fetch phase (T0–T2) followed by an opcode-specific execute phase (T3–T7).
- Stalls on a memory ready handshake.
- Sits beside the datapath; the only datapath state it reads is the IR contents.

Parameters:
- ALU_ADD, 5'd3, aluControl code for add; also used for address and PC arithmetic.
- ALU_SUB, 5'd4, aluControl code for sub.
- ALU_AND, 5'd5, aluControl code for and.
- ALU_OR, 5'd6, aluControl code for or.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clock  in  1  sole clock, rising edge.
- clear  in  1  reset, asynchronous, active-high.
- run  in  1  level; starts or resumes sequencing from IDLE.
- ir  in  32  IR contents: op=[31:27], Ra=[26:23], Rb=[22:19], Rc=[18:15], C=[18:0].
- mem_rdy  in  1  memory completion for the current Read or Write.
- PCout, ZLOout, MDRout, Cout, Rout, BAout  out  1 each  bus-source enables.
- PCin, IRin, MARin, MDRin, Yin, Zin, Rin  out  1 each  register-load enables.
- Gra, Grb, Grc  out  1 each  register-field select strobes.
- IncPC, Read, Write  out  1 each  PC increment and memory strobes.
- aluControl  out  5  ALU operation.
- halted  out  1  high in HALT.
- illegal  out  1  one-cycle pulse on an undefined opcode.
- instr_count  out  CNT_W  retired instructions; wraps at 2^CNT_W.

Behaviour:
- Outputs are combinational decodes of the registered state and ir.
- On clear, and in IDLE/HALT, every output is 0 except instr_count and halted; instr_count resets to 0.
- clear mid-instruction aborts immediately to IDLE with all strobes low.
- States: IDLE, T0..T7, HALT. IDLE→T0 when run=1.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin, aluControl=ALU_ADD.
  - T1: ZLOout, PCin, Read, MDRin. Holds T1 with Read and MDRin asserted until mem_rdy=1; PCin asserts only in the mem_rdy cycle.
  - T2: MDRout, IRin.
  - The IR is decoded in T3 (ir valid from T3).
- Opcodes: ld=00000, ldi=00001, st=00010, add=00011, sub=00100, and=00101, or=00110, addi=01000, halt=11011.
- ld:
  - T3: Grb, BAout, Yin.
  - T4: Cout, ALU_ADD, Zin.
  - T5: ZLOout, MARin.
  - T6: Read, MDRin; wait for mem_rdy.
  - T7: MDRout, Gra, Rin.
- ldi: T3 and T4 as ld; T5: ZLOout, Gra, Rin.
- st:
  - T3–T5 as ld.
  - T6: Gra, Rout, MDRin (Read=0, so MDR loads from the bus).
  - T7: Write; wait for mem_rdy.
- add/sub/and/or:
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zin, aluControl mapped from op.
  - T5: ZLOout, Gra, Rin.
- addi: as add, but T4 uses Cout instead of Grc/Rout.
- halt: T3→HALT. HALT exits only on clear.
- Undefined op: illegal pulses in T3, then next state follows the end-of-instruction rule; instr_count is not incremented.
- End of instruction (last execute state, after mem_rdy where required):
  - instr_count += 1.
  - Next state is T0 (IDLE instead if STEP_EN is defined, or if run=0).
- Latency with mem_rdy tied high: ALU/ldi = 6 cycles, ld/st = 8 cycles. Each mem_rdy=0 cycle adds one.
- mem_rdy is ignored outside T1, T6 (ld) and T7 (st).
- Only one bus-source enable is asserted in any cycle; this is a checked invariant.

Optional Feature:
- Macro: DCU_SINGLE_STEP_EN.
- Defined: after each instruction the unit returns to IDLE and needs a fresh run rising edge (edge detected internally) to fetch the next one.
- Undefined: runs back-to-back while run=1; the edge detector is absent.

Decomposition:
- Package dcu_pkg holds:
  - state enum (IDLE, T0..T7, HALT);
  - opcode localparams;
  - IR field bit-position constants.
- Sub-module dcu_decode: purely combinational map of (state, op) to the control-strobe bundle and aluControl.
- Top level holds the state register, wait logic, counter and step logic.

Test Plan:
- Reset then run=1, ir=add R1,R2,R3 (0x18918000), mem_rdy=1:
  - T0: PCout/MARin/IncPC;
  - T4: Grc/Rout/Zin with aluControl=5'd3;
  - T5: Gra/Rin;
  - instr_count=1 after 6 cycles.
- ld with mem_rdy low 3 cycles in T1 and 2 in T6: Read held through each wait, PCin pulses once, total 13 cycles.
- st R5, 0x10(R0): T3 asserts BAout (not Rout), T6 Gra/Rout/MDRin, T7 Write held until mem_rdy.
- ir opcode 10101: illegal=1 for exactly one cycle, instr_count unchanged, next state T0.
- halt: halted=1 and all strobes 0 for 20 cycles; clear returns to IDLE with instr_count=0.
- clear asserted mid-T6 of ld: all outputs 0 in the same cycle, state IDLE. With DCU_SINGLE_STEP_EN, two instructions need two run pulses.
